// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive path.
// Optional parity support is selected with the UART_TX_PARITY_EN macro in uart_tx_serializer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Smallest width that can count 0 .. data_bits-1 (never below 1).
    function automatic int unsigned uart_cnt_width(input int unsigned data_bits);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < data_bits) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// Turns a toggling bit clock into a one-cycle tick on the system clock.
// The bit clock is treated purely as data; usable on tx_clk or rx_clk.
module uart_tick_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_clk,
    output logic tick
);

    logic bit_clk_d;
    logic bit_clk_q;

    always_comb begin
        bit_clk_d = bit_clk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_clk_q <= 1'b0;
        end else begin
            bit_clk_q <= bit_clk_d;
        end
    end

    assign tick = bit_clk ^ bit_clk_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
// Parity is compiled in when UART_TX_PARITY_EN is defined; PARITY_ODD selects its sense.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 baud_clk,
    input  logic                 baud_rst_n,
    input  logic                 tx_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_out
);

    localparam int unsigned    CNT_W     = uart_cnt_width(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2)
        || (PARITY_ODD > 1)) begin : g_param_check
        $error("uart_tx_serializer: illegal parameter value");
    end

    logic tick;

    uart_tick_detect u_tick_detect (
        .clk     (baud_clk),
        .rst_n   (baud_rst_n),
        .bit_clk (tx_clk),
        .tick    (tick)
    );

    uart_state_e            state_d,  state_q;
    logic [DATA_BITS-1:0]   shift_d,  shift_q;
    logic [CNT_W-1:0]       cnt_d,    cnt_q;
    logic                   tx_out_d, tx_out_q;
    logic                   tx_done_d, tx_done_q;
`ifdef UART_TX_PARITY_EN
    logic                   parity_d, parity_q;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tx_out_d  = tx_out_q;
        tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_out_d = UART_IDLE_LEVEL;
                if (tx_valid) begin
                    shift_d = tx_data;
                    cnt_d   = '0;
                    state_d = ST_ARM;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            // A tick seen during the acceptance cycle is intentionally ignored (still IDLE).
            ST_ARM: begin
                if (tick) begin
                    state_d  = ST_START;
                    tx_out_d = UART_START_LEVEL;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d  = ST_DATA;
                    tx_out_d = shift_q[0];
                    cnt_d    = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (cnt_q == LAST_DATA) begin
                        cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
                        tx_out_d = parity_q;
`else
                        state_d  = ST_STOP;
                        tx_out_d = UART_IDLE_LEVEL;
`endif
                    end else begin
                        shift_d  = shift_q >> 1;
                        cnt_d    = cnt_q + CNT_W'(1);
                        tx_out_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d  = ST_STOP;
                    tx_out_d = UART_IDLE_LEVEL;
                    cnt_d    = '0;
                end
            end
`endif
            ST_STOP: begin
                tx_out_d = UART_IDLE_LEVEL;
                if (tick) begin
                    if (cnt_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        tx_done_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_out_d = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge baud_clk or negedge baud_rst_n) begin
        if (!baud_rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_out_q  <= UART_IDLE_LEVEL;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tx_out_q  <= tx_out_d;
            tx_done_q <= tx_done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge baud_clk or negedge baud_rst_n) begin
        if (!baud_rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = tx_done_q;
    assign tx_out   = tx_out_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: two instances (1 stop/even, 2 stop/odd)
// driven by a 16-cycle-per-bit tx_clk, checked against a frame-level reference model.
module tb_uart_tx_serializer;

    localparam int BIT_CYC = 16;
    localparam int P1_ODD  = 0;
    localparam int P2_ODD  = 1;

    logic       baud_clk   = 1'b0;
    logic       baud_rst_n = 1'b0;
    logic       tx_clk     = 1'b0;
    logic [7:0] tx_data    = '0;
    logic       tx_valid   = 1'b0;
    logic       sel        = 1'b0;

    logic valid1, ready1, busy1, done1, out1;
    logic valid2, ready2, busy2, done2, out2;
    logic ready_m, busy_m, done_m, out_m;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    assign valid1  = tx_valid & ~sel;
    assign valid2  = tx_valid & sel;
    assign ready_m = sel ? ready2 : ready1;
    assign busy_m  = sel ? busy2  : busy1;
    assign done_m  = sel ? done2  : done1;
    assign out_m   = sel ? out2   : out1;

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(P1_ODD)) u_dut1 (
        .baud_clk   (baud_clk),
        .baud_rst_n (baud_rst_n),
        .tx_clk     (tx_clk),
        .tx_data    (tx_data),
        .tx_valid   (valid1),
        .tx_ready   (ready1),
        .tx_busy    (busy1),
        .tx_done    (done1),
        .tx_out     (out1)
    );

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(P2_ODD)) u_dut2 (
        .baud_clk   (baud_clk),
        .baud_rst_n (baud_rst_n),
        .tx_clk     (tx_clk),
        .tx_data    (tx_data),
        .tx_valid   (valid2),
        .tx_ready   (ready2),
        .tx_busy    (busy2),
        .tx_done    (done2),
        .tx_out     (out2)
    );

    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc <= cyc + 1;

    // Baud generator stand-in: tx_clk toggles once per 16 cycles, so tick edges land on cyc%16==1.
    initial begin
        forever begin
            @(posedge baud_clk);
            #1;
            if (cyc % BIT_CYC == 0) tx_clk = ~tx_clk;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 50000 cycles without finishing");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int stop_bits);
        int n;
        n = 1 + 8 + stop_bits;
`ifdef UART_TX_PARITY_EN
        n = n + 1;
`endif
        return n;
    endfunction

    // Line level per bit period: start low, data LSB first, optional parity, stops high.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int odd);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = (^d) ^ (odd != 0);
`else
        if (odd > 1) f = '0;
`endif
        return f;
    endfunction

    task automatic send(input logic [7:0] d, output int acc);
        for (int k = 0; k < 400; k++) begin
            if (ready_m === 1'b1) break;
            @(negedge baud_clk);
        end
        chk("send_ready", ready_m, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge baud_clk);
        #1;
        acc      = cyc;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Start edge must be the first tick edge strictly after the acceptance edge.
    task automatic wait_start(input int acc, input string tag, output int s, output bit ok);
        int exp_s;
        exp_s = acc + 1;
        while (exp_s % BIT_CYC != 1) exp_s++;
        @(negedge baud_clk);
        chk({tag, " ready_low"}, ready_m, 0);
        chk({tag, " busy_high"}, busy_m, 1);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_m === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge baud_clk);
        end
        s = cyc;
        chk({tag, " start_cycle"}, s, exp_s);
    endtask

    task automatic check_frame(input logic [7:0] d, input int acc, input int stop_bits,
                               input int odd, input string tag);
        int s;
        bit ok;
        int n;
        int good;
        int bad_done;
        logic [15:0] f;
        wait_start(acc, tag, s, ok);
        if (!ok) return;
        n        = frame_len(stop_bits);
        f        = frame_bits(d, odd);
        bad_done = 0;
        for (int b = 0; b < n; b++) begin
            good = 0;
            for (int j = 0; j < BIT_CYC; j++) begin
                if (out_m === f[b]) good++;
                if (done_m !== 1'b0) bad_done++;
                @(negedge baud_clk);
            end
            chk($sformatf("%s bit%0d", tag, b), good, BIT_CYC);
        end
        chk({tag, " no_early_done"}, bad_done, 0);
        chk({tag, " done_pulse"}, done_m, 1);
        chk({tag, " ready_at_done"}, ready_m, 1);
        chk({tag, " busy_at_done"}, busy_m, 0);
        chk({tag, " line_idle"}, out_m, 1);
    endtask

    initial begin
        int acc;
        int acc2;
        int s;
        bit ok;
        int hi_cnt;
        int done_cnt;
        int busy_cnt;
        logic [7:0] d;

        // Reset
        baud_rst_n = 1'b0;
        repeat (5) @(posedge baud_clk);
        @(negedge baud_clk);
        baud_rst_n = 1'b1;
        chk("rst tx_out", out1, 1);
        chk("rst tx_ready", ready1, 1);
        chk("rst tx_busy", busy1, 0);
        chk("rst tx_done", done1, 0);
        chk("rst dut2 tx_out", out2, 1);
        chk("rst dut2 tx_ready", ready2, 1);

        // Idle with no valid: line stays high, no activity
        hi_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge baud_clk);
            if (out1 === 1'b1 && out2 === 1'b1) hi_cnt++;
            if (done1 !== 1'b0 || done2 !== 1'b0) done_cnt++;
            if (busy1 !== 1'b0 || busy2 !== 1'b0) busy_cnt++;
        end
        chk("idle line_high", hi_cnt, 200);
        chk("idle no_done", done_cnt, 0);
        chk("idle not_busy", busy_cnt, 0);

        // Single byte 0xA5
        sel = 1'b0;
        send(8'hA5, acc);
        check_frame(8'hA5, acc, 1, P1_ODD, "a5");
        @(negedge baud_clk);
        chk("a5 done_one_cycle", done_m, 0);

        // Back-to-back with tx_valid held: 0x00 then 0xFF
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge baud_clk);
        #1;
        acc     = cyc;
        tx_data = 8'hFF;
        check_frame(8'h00, acc, 1, P1_ODD, "b2b0");
        @(posedge baud_clk);
        #1;
        acc2     = cyc;
        tx_valid = 1'b0;
        chk("b2b accept_after_done", acc2, acc2 > acc ? acc2 : -1);
        check_frame(8'hFF, acc2, 1, P1_ODD, "b2b1");
        @(negedge baud_clk);
        chk("b2b only_two_frames", busy_m, 0);

        // Handshake: valid pulse while busy ignored, data change after acceptance ignored
        d = 8'($urandom);
        send(d, acc);
        fork
            check_frame(d, acc, 1, P1_ODD, "hs");
            begin
                repeat (40) @(negedge baud_clk);
                tx_data  = ~d;
                tx_valid = 1'b1;
                @(negedge baud_clk);
                tx_valid = 1'b0;
            end
        join
        @(negedge baud_clk);
        chk("hs pulse_ignored", busy_m, 0);

        // Parity sense on both instances; dut2 also has two stop bits
        send(8'h07, acc);
        check_frame(8'h07, acc, 1, P1_ODD, "par_even_07");
        sel = 1'b1;
        send(8'h07, acc);
        check_frame(8'h07, acc, 2, P2_ODD, "stop2_odd_07");
        sel = 1'b0;

        // Randomized frames with random idle gaps (varies the ARM latency)
        for (int r = 0; r < 8; r++) begin
            @(negedge baud_clk);
            sel = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge baud_clk);
            send(d, acc);
            if (sel) check_frame(d, acc, 2, P2_ODD, $sformatf("rnd%0d_d2", r));
            else     check_frame(d, acc, 1, P1_ODD, $sformatf("rnd%0d_d1", r));
        end
        @(negedge baud_clk);
        sel = 1'b0;

        // Mid-frame reset during data bit 3 of 0x3C
        send(8'h3C, acc);
        wait_start(acc, "mrst", s, ok);
        done_cnt = 0;
        for (int k = 0; k < BIT_CYC * 4 + 5; k++) begin
            @(negedge baud_clk);
            if (done_m !== 1'b0) done_cnt++;
        end
        baud_rst_n = 1'b0;
        #1;
        chk("mrst tx_out_async", out_m, 1);
        chk("mrst ready_async", ready_m, 1);
        chk("mrst busy_async", busy_m, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge baud_clk);
            if (done_m !== 1'b0) done_cnt++;
        end
        baud_rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge baud_clk);
            if (done_m !== 1'b0) done_cnt++;
        end
        chk("mrst no_done", done_cnt, 0);
        send(8'h55, acc);
        check_frame(8'h55, acc, 1, P1_ODD, "mrst_55");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit serializer that sits directly downstream of the baud generator, consuming its tx_clk output.
- Runs entirely on baud_clk. tx_clk is used only as a data signal: each toggle of tx_clk marks one bit-period boundary. No logic is clocked by tx_clk.
- Accepts bytes over a valid/ready handshake and drives the serial line: start bit, data bits LSB first, optional parity, stop bit(s).

Parameters:
- DATA_BITS, 8, payload width per frame; legal range 5..9.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- baud_clk  input  1  system clock; same clock as the baud generator.
- baud_rst_n  input  1  reset, asynchronous, active-low.
- tx_clk  input  1  toggling bit clock from the baud generator; each edge = one bit tick.
- tx_data  input  DATA_BITS  byte to send; sampled on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte.
- tx_busy  output  1  a frame is pending or in progress.
- tx_done  output  1  one-cycle pulse at the end of the last stop bit.
- tx_out  output  1  serial line, idle high.

Behaviour:
- Tick detection:
  - tx_clk_d registers tx_clk; resets to 0.
  - tick = tx_clk XOR tx_clk_d.
  - One bit period = the baud_clk cycles between consecutive ticks.
- Reset values (asynchronous): state IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, shift register 0, bit counter 0.
- States: IDLE, ARM, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, tx_busy=0, tx_out=1.
  - If tx_valid && tx_ready at a clock edge: latch tx_data into the shift register, go to ARM. tx_ready drops the next cycle.
- ARM:
  - Line stays high; waits for the next tick.
  - A tick in the acceptance cycle itself is not used; acceptance never starts the start bit in the same cycle.
  - On tick: go to START, tx_out=0.
  - Latency from acceptance to the falling edge of the start bit is 1 to (one bit period + 1) cycles.
- START: on tick, go to DATA; tx_out=shift[0]; bit counter=0.
- DATA:
  - On each tick, shift right and increment the counter. tx_out follows the new LSB.
  - After DATA_BITS bits: go to PARITY if compiled in, else STOP with tx_out=1.
- STOP:
  - tx_out=1 for STOP_BITS bit periods.
  - On the final tick: tx_done=1 for exactly one cycle, go to IDLE, tx_ready=1 the same cycle.
- Back-to-back: a byte presented during the tx_done cycle is not accepted until tx_ready is high (the following edge). The next start bit then begins on the tick after that.
- tx_busy = (state != IDLE). tx_ready = (state == IDLE).
- tx_out is registered; no combinational path from inputs to tx_out.
- tx_valid deasserted while not ready: no effect. tx_data changes after acceptance: no effect.
- Reset mid-frame: tx_out returns high immediately (async); the frame is abandoned with no tx_done.
- If tx_clk stops toggling, the FSM holds its current state indefinitely (no timeout).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA and lasts one bit period.
  - Parity bit = XOR of the latched data, inverted when PARITY_ODD=1. It is computed at acceptance and held in a register.
  - Frame length = 1 + DATA_BITS + 1 + STOP_BITS bits.
- Undefined:
  - No PARITY state, no parity register, and PARITY_ODD is ignored.
  - Frame length = 1 + DATA_BITS + STOP_BITS bits.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, ARM, START, DATA, PARITY, STOP);
  - localparams UART_IDLE_LEVEL=1 and UART_START_LEVEL=0;
  - a function computing the bit-counter width from DATA_BITS.
- Sub-module uart_tick_detect: registers tx_clk and outputs the one-cycle tick. It is reusable by the receive side on rx_clk.

Test Plan:
- Common setup: baud generator with clk_rate=1_600_000, baud_rate=100_000, giving 16 cycles per bit.
- Reset: hold baud_rst_n=0 for 5 cycles, then release -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0. No toggles for 200 cycles with tx_valid=0.
- Single byte: send 0xA5 -> line shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1. Each bit is 16 cycles wide ±0. tx_done pulses once, 160 cycles after the start-bit edge.
- Back-to-back: hold tx_valid=1 with 0x00 then 0xFF -> two complete frames. Between them is only the ARM gap, at most 16 cycles of idle high. Exactly two tx_done pulses.
- Parity (UART_TX_PARITY_EN defined):
  - PARITY_ODD=0, send 0x07 -> parity bit 1.
  - PARITY_ODD=1, send 0x07 -> parity bit 0.
  - Frame = 11 bits (176 cycles).
- Mid-frame reset: assert baud_rst_n=0 during data bit 3 of 0x3C -> tx_out=1 in the same cycle. No tx_done. After release, a new byte 0x55 is transmitted correctly.
- Handshake: tx_valid pulsed for one cycle while busy is ignored. tx_data changed after acceptance does not alter the frame in progress. STOP_BITS=2 gives a stop-high period of 32 cycles.
